prog_mem: RTL

PROG_MEM -- requirements
Module: prog_mem

---
 rtl/prog_mem.sv | 125 ++++++++++++
 1 files changed

// File: rtl/prog_mem.sv
// Program memory for a small MCU core: loaded byte-by-byte over a ready/valid
// stream, zero-filled past the last byte, then served to the core in RUN.
module prog_mem #(
    parameter int AW = 5,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_start,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic          ld_done,
    output logic          cpu_reset,
    input  logic          rd,
    input  logic          wr,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] TOP_ADDR = (AW + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FILL,
        RUN
    } state_t;

    state_t state, next_state;
    logic [AW:0] lptr, next_lptr;
    logic [DW-1:0] mem [DEPTH];

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          at_top;

    assign at_top = (lptr == TOP_ADDR);

    // load_start beats every other activity, so a byte or MCU write offered
    // in the same cycle is simply never turned into a memory write.
    always_comb begin
        next_state = state;
        next_lptr  = lptr;
        mem_we     = 1'b0;
        mem_waddr  = lptr[AW-1:0];
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                if (load_start) begin
                    next_state = LOAD;
                    next_lptr  = '0;
                end
            end
            LOAD: begin
                if (load_start) begin
                    next_lptr = '0;
                end else if (ld_valid) begin
                    mem_we    = 1'b1;
                    mem_wdata = ld_data;
                    next_lptr = lptr + 1'b1;
                    if (at_top) begin
                        next_state = RUN;
                    end else if (ld_last) begin
                        next_state = FILL;
                    end
                end
            end
            FILL: begin
                if (load_start) begin
                    next_state = LOAD;
                    next_lptr  = '0;
                end else begin
                    mem_we    = 1'b1;
                    next_lptr = lptr + 1'b1;
                    if (at_top) begin
                        next_state = RUN;
                    end
                end
            end
            RUN: begin
                if (load_start) begin
                    next_state = LOAD;
                    next_lptr  = '0;
                end else if (wr) begin
                    mem_we    = 1'b1;
                    mem_waddr = addr;
                    mem_wdata = wdata;
                end
            end
            default: begin
                next_state = IDLE;
                next_lptr  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            lptr    <= '0;
            ld_done <= 1'b0;
        end else begin
            state   <= next_state;
            lptr    <= next_lptr;
            ld_done <= (next_state == RUN) && (state != RUN);
        end
    end

    // Storage is deliberately not reset; reset only suppresses the write.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign cpu_reset = (state != RUN);
    assign ld_ready  = (state == LOAD);
    assign rdata     = (state == RUN && rd) ? mem[addr] : '0;

endmodule
